fwd_bypass_unit: RTL and testbench

- Parametrised successor to the single-operand ALU forwarding mux. Resolves every source operand of the instruction in ID against all in-flight results (EX plus DEPTH retire stages).
- Detects load-use hazards and stalls ID.
- Registers the resolved operands, acting as the operand half of the ID/EX latch.
- Sits between the register file read port and the ALU input in the pipelined 8-bit core.

---
 rtl/fwd_bypass_unit_pkg.sv | 39 +++
 rtl/fwd_bypass_unit_operand_sel.sv | 85 ++++++++
 rtl/fwd_bypass_unit.sv | 161 ++++++++++++++++
 tb/tb_fwd_bypass_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_bypass_unit_pkg.sv
// -----------------------------------------------------------------------------
// fwd_bypass_unit_pkg
// Shared definitions for the operand forwarding / bypass unit:
//   - fwd_sel encoding constants (0 = register file, 1 = EX, k+1 = retire stage Sk)
//   - the in-flight result tracker entry
//   - a constant clog2 helper for sizing the select field
// The tracker entry is sized for the widest supported datapath; narrower
// instances zero-extend into it. DATA_W must not exceed TRK_DATA_W_MAX and
// REG_AW must not exceed TRK_REG_AW_MAX.
// -----------------------------------------------------------------------------
package fwd_bypass_unit_pkg;

    localparam int TRK_DATA_W_MAX = 32;
    localparam int TRK_REG_AW_MAX = 8;

    localparam int SEL_RF         = 0;
    localparam int SEL_EX         = 1;
    localparam int SEL_STAGE_BASE = 1;   // stage Sk encodes as SEL_STAGE_BASE + k

    typedef struct packed {
        logic                        valid;
        logic [TRK_REG_AW_MAX-1:0]   dest;
        logic [TRK_DATA_W_MAX-1:0]   data;
        logic                        is_load;
    } trk_entry_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fwd_bypass_unit_operand_sel.sv
// -----------------------------------------------------------------------------
// fwd_operand_sel
// Purely combinational priority match for one source operand. Compares the
// operand address against EX and every tracked retire stage and returns the
// youngest matching value.
//   src_addr       in   operand register address
//   rf_data        in   register file read data for this operand
//   ex_wr          in   EX holds a real register write (ex_valid & ex_wen)
//   ex_dest        in   EX destination register
//   ex_result      in   EX ALU result
//   ex_is_load     in   EX is a load (result not yet available)
//   mem_load_data  in   load data for the entry in S1
//   stage          in   tracker entries S1..SDEPTH
//   data           out  resolved operand value
//   sel            out  source of the value (0 RF, 1 EX, k+1 Sk)
//   load_hazard    out  youngest match is a load still in EX
// -----------------------------------------------------------------------------
module fwd_operand_sel
    import fwd_bypass_unit_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REG_AW      = 2,
    parameter int DEPTH       = 2,
    parameter int ZERO_REG_EN = 0,
    parameter int SEL_W       = 2
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_wr,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] mem_load_data,
    input  trk_entry_t        stage [1:DEPTH],
    output logic [DATA_W-1:0] data,
    output logic [SEL_W-1:0]  sel,
    output logic              load_hazard
);

    logic [TRK_DATA_W_MAX-1:0] data_full;
    logic [TRK_REG_AW_MAX-1:0] addr_full;
    logic                      unused_data_hi;

    always_comb begin
        data_full                 = '0;
        data_full[DATA_W-1:0]     = rf_data;
        sel                       = SEL_W'(SEL_RF);
        load_hazard               = 1'b0;
        addr_full                 = '0;
        addr_full[REG_AW-1:0]     = src_addr;

        // Walk from the oldest stage to the youngest so the youngest match
        // is the one left standing.
        for (int k = DEPTH; k >= 1; k--) begin
            if (stage[k].valid && (stage[k].dest == addr_full)) begin
                if ((k == 1) && stage[k].is_load) begin
                    // A load's data field still holds the address-phase
                    // ALU result; the real value arrives from memory now.
                    data_full             = '0;
                    data_full[DATA_W-1:0] = mem_load_data;
                end else begin
                    data_full = stage[k].data;
                end
                sel = SEL_W'(SEL_STAGE_BASE + k);
            end
        end

        if (ex_wr && (ex_dest == src_addr)) begin
            data_full             = '0;
            data_full[DATA_W-1:0] = ex_result;
            sel                   = SEL_W'(SEL_EX);
            load_hazard           = ex_is_load;
        end

        if ((ZERO_REG_EN != 0) && (src_addr == '0)) begin
            data_full   = '0;
            sel         = SEL_W'(SEL_RF);
            load_hazard = 1'b0;
        end
    end

    assign data           = data_full[DATA_W-1:0];
    assign unused_data_hi = ^data_full[TRK_DATA_W_MAX-1:DATA_W];

endmodule

// File: rtl/fwd_bypass_unit.sv
// -----------------------------------------------------------------------------
// fwd_bypass_unit
// Resolves every source operand of the ID instruction against all in-flight
// results (EX plus DEPTH retire stages), stalls on load-use, and registers
// the resolved operands as the operand half of the ID/EX latch.
//   clk, rst_n     clock, asynchronous active-low reset
//   ex_*           instruction currently in EX (valid, write enable, dest,
//                  result, load flag)
//   mem_load_data  load data for the tracker entry in S1
//   id_valid       ID holds a real instruction
//   id_src_addr    packed source addresses, operand 0 in the LSBs
//   id_rf_data     packed register file read data
//   flush          kill the ID instruction
//   op_data        registered resolved operands
//   op_valid       op_data belongs to an issued instruction
//   fwd_sel        registered source per operand (0 RF, 1 EX, k+1 Sk)
//   stall          combinational load-use stall
//   fwd_count      saturating count of forwarded operands
// -----------------------------------------------------------------------------
module fwd_bypass_unit
    import fwd_bypass_unit_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REG_AW      = 2,
    parameter int NUM_SRC     = 2,
    parameter int DEPTH       = 2,
    parameter int ZERO_REG_EN = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ex_valid,
    input  logic                                  ex_wen,
    input  logic [REG_AW-1:0]                     ex_dest,
    input  logic [DATA_W-1:0]                     ex_result,
    input  logic                                  ex_is_load,
    input  logic [DATA_W-1:0]                     mem_load_data,
    input  logic                                  id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]             id_src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]             id_rf_data,
    input  logic                                  flush,
    output logic [NUM_SRC*DATA_W-1:0]             op_data,
    output logic                                  op_valid,
    output logic [NUM_SRC*clog2(DEPTH+2)-1:0]     fwd_sel,
    output logic                                  stall,
    output logic [15:0]                           fwd_count
);

    localparam int SEL_W = clog2(DEPTH + 2);

    trk_entry_t                trk_q [1:DEPTH];
    trk_entry_t                trk_d [1:DEPTH];

    logic [NUM_SRC*DATA_W-1:0] res_data;
    logic [NUM_SRC*SEL_W-1:0]  res_sel;
    logic [NUM_SRC-1:0]        res_hazard;
    logic                      issue;

    logic [NUM_SRC*DATA_W-1:0] op_data_q,   op_data_d;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_q,   fwd_sel_d;
    logic                      op_valid_q,  op_valid_d;
    logic [15:0]               fwd_count_q, fwd_count_d;
    logic [16:0]               fwd_inc;
    logic [16:0]               count_sum;

    // Tracker: shifts every cycle, independent of stall. Loads pick up their
    // memory data on the S1 -> S2 move so S2 onward always hold final values.
    always_comb begin
        trk_d[1]                      = '0;
        trk_d[1].valid                = ex_valid & ex_wen;
        trk_d[1].dest[REG_AW-1:0]     = ex_dest;
        trk_d[1].data[DATA_W-1:0]     = ex_result;
        trk_d[1].is_load              = ex_is_load;
        for (int k = 2; k <= DEPTH; k++) begin
            trk_d[k] = trk_q[k-1];
            if ((k == 2) && trk_q[1].is_load) begin
                trk_d[k].data             = '0;
                trk_d[k].data[DATA_W-1:0] = mem_load_data;
            end
            trk_d[k].is_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                trk_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                trk_q[k] <= trk_d[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_operand_sel #(
            .DATA_W      (DATA_W),
            .REG_AW      (REG_AW),
            .DEPTH       (DEPTH),
            .ZERO_REG_EN (ZERO_REG_EN),
            .SEL_W       (SEL_W)
        ) u_operand_sel (
            .src_addr      (id_src_addr[g*REG_AW +: REG_AW]),
            .rf_data       (id_rf_data[g*DATA_W +: DATA_W]),
            .ex_wr         (ex_valid & ex_wen),
            .ex_dest       (ex_dest),
            .ex_result     (ex_result),
            .ex_is_load    (ex_is_load),
            .mem_load_data (mem_load_data),
            .stage         (trk_q),
            .data          (res_data[g*DATA_W +: DATA_W]),
            .sel           (res_sel[g*SEL_W +: SEL_W]),
            .load_hazard   (res_hazard[g])
        );
    end

    // flush wins over stall: a killed instruction never holds the front end.
    assign stall = id_valid & ~flush & (|res_hazard);
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        op_data_d   = op_data_q;
        fwd_sel_d   = fwd_sel_q;
        op_valid_d  = 1'b0;
        fwd_count_d = fwd_count_q;
        fwd_inc     = '0;
        count_sum   = '0;
        for (int g = 0; g < NUM_SRC; g++) begin
            if (res_sel[g*SEL_W +: SEL_W] != '0) begin
                fwd_inc = fwd_inc + 17'd1;
            end
        end
        if (issue) begin
            op_data_d   = res_data;
            fwd_sel_d   = res_sel;
            op_valid_d  = 1'b1;
            count_sum   = {1'b0, fwd_count_q} + fwd_inc;
            fwd_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_data_q   <= '0;
            fwd_sel_q   <= '0;
            op_valid_q  <= 1'b0;
            fwd_count_q <= '0;
        end else begin
            op_data_q   <= op_data_d;
            fwd_sel_q   <= fwd_sel_d;
            op_valid_q  <= op_valid_d;
            fwd_count_q <= fwd_count_d;
        end
    end

    assign op_data   = op_data_q;
    assign fwd_sel   = fwd_sel_q;
    assign op_valid  = op_valid_q;
    assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_bypass_unit
// Scoreboard bench for fwd_bypass_unit at default parameters. A behavioural
// model of the tracker and issue register predicts each cycle's outputs; the
// expectation is queued when stimulus is applied and compared after the edge.
// -----------------------------------------------------------------------------
module tb_fwd_bypass_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_wen, ex_is_load;
    logic [1:0]  ex_dest;
    logic [7:0]  ex_result, mem_load_data;
    logic        id_valid, flush;
    logic [3:0]  id_src_addr;
    logic [15:0] id_rf_data;
    logic [15:0] op_data;
    logic        op_valid;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] fwd_count;

    always #5 clk = ~clk;

    fwd_bypass_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_wen        (ex_wen),
        .ex_dest       (ex_dest),
        .ex_result     (ex_result),
        .ex_is_load    (ex_is_load),
        .mem_load_data (mem_load_data),
        .id_valid      (id_valid),
        .id_src_addr   (id_src_addr),
        .id_rf_data    (id_rf_data),
        .flush         (flush),
        .op_data       (op_data),
        .op_valid      (op_valid),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .fwd_count     (fwd_count)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  sel;
        logic        vld;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    logic [7:0]  rf [0:3];
    bit          m_v   [1:2];
    logic [1:0]  m_dst [1:2];
    logic [7:0]  m_dat [1:2];
    bit          m_ld  [1:2];
    logic [15:0] m_op_data;
    logic [3:0]  m_sel;
    logic        m_opv;
    logic [15:0] m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= 2; k++) begin
            m_v[k] = 0; m_dst[k] = '0; m_dat[k] = '0; m_ld[k] = 0;
        end
        m_op_data = '0; m_sel = '0; m_opv = 1'b0; m_cnt = '0;
        sb_q.delete();
    endtask

    task automatic drive(input bit exv, input bit exw, input logic [1:0] exd,
                         input logic [7:0] exr, input bit exl, input logic [7:0] mld,
                         input bit idv, input logic [1:0] a0, input logic [1:0] a1,
                         input bit fl);
        ex_valid = exv; ex_wen = exw; ex_dest = exd; ex_result = exr;
        ex_is_load = exl; mem_load_data = mld; id_valid = idv;
        id_src_addr = {a1, a0};
        id_rf_data  = {rf[a1], rf[a0]};
        flush = fl;
    endtask

    // Reference resolution: search youngest first and stop at the first hit.
    task automatic resolve(input int i, output logic [7:0] d, output logic [1:0] s, output bit hz);
        logic [1:0] a;
        bit         found;
        a = id_src_addr[i*2 +: 2];
        d = rf[a]; s = 2'd0; hz = 0; found = 0;
        if (ex_valid && ex_wen && ex_dest == a) begin
            d = ex_result; s = 2'd1; hz = ex_is_load; found = 1;
        end
        for (int k = 1; k <= 2; k++) begin
            if (!found && m_v[k] && m_dst[k] == a) begin
                d = (k == 1 && m_ld[1]) ? mem_load_data : m_dat[k];
                s = 2'(k + 1);
                found = 1;
            end
        end
    endtask

    // Called just after a falling edge with inputs applied; returns at the
    // next falling edge.
    task automatic step(input string tag);
        logic [15:0] nd;
        logic [3:0]  ns;
        logic [7:0]  d;
        logic [1:0]  s;
        bit          hz, hz_any, exp_stall, iss;
        int          nf, t;
        exp_t        e;
        hz_any = 0; nf = 0; nd = '0; ns = '0;
        for (int i = 0; i < 2; i++) begin
            resolve(i, d, s, hz);
            nd[i*8 +: 8] = d;
            ns[i*2 +: 2] = s;
            hz_any |= hz;
            if (s != 2'd0) nf++;
        end
        exp_stall = id_valid && !flush && hz_any;
        #1;
        check_val({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        iss = id_valid && !exp_stall && !flush;
        if (iss) begin
            m_op_data = nd; m_sel = ns; m_opv = 1'b1;
            t = int'(m_cnt) + nf;
            m_cnt = (t > 65535) ? 16'hFFFF : 16'(t);
        end else begin
            m_opv = 1'b0;
        end
        e.data = m_op_data; e.sel = m_sel; e.vld = m_opv; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        m_v[2] = m_v[1]; m_dst[2] = m_dst[1];
        m_dat[2] = m_ld[1] ? mem_load_data : m_dat[1];
        m_ld[2] = 0;
        m_v[1] = ex_valid && ex_wen; m_dst[1] = ex_dest;
        m_dat[1] = ex_result; m_ld[1] = ex_is_load;
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_op_valid"},  32'(op_valid),  32'(e.vld));
            check_val({tag, "_op_data"},   32'(op_data),   32'(e.data));
            check_val({tag, "_fwd_sel"},   32'(fwd_sel),   32'(e.sel));
            check_val({tag, "_fwd_count"}, 32'(fwd_count), 32'(e.cnt));
        end
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_op_data"},   32'(op_data),   32'd0);
        check_val({tag, "_op_valid"},  32'(op_valid),  32'd0);
        check_val({tag, "_fwd_sel"},   32'(fwd_sel),   32'd0);
        check_val({tag, "_fwd_count"}, 32'(fwd_count), 32'd0);
    endtask

    initial begin
        rf[0] = 8'h00; rf[1] = 8'h11; rf[2] = 8'h22; rf[3] = 8'h33;
        rst_n = 1'b0;
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'd0, 2'd0, 0);
        model_reset();
        @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // RF only
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00, 1, 2'd1, 2'd2, 0);
        step("rf_only");
        // EX forward
        drive(1, 1, 2'd1, 8'h3C, 0, 8'h00, 1, 2'd1, 2'd2, 0);
        step("ex_fwd");
        // r1=A0 heads into S1
        drive(1, 1, 2'd1, 8'hA0, 0, 8'h00, 0, 2'd0, 2'd0, 0);
        step("fill_s1");
        // EX (55) beats S1 (A0) and S2 (3C); duplicate sources
        drive(1, 1, 2'd1, 8'h55, 0, 8'h00, 1, 2'd1, 2'd1, 0);
        step("youngest_ex");
        // S1 (55) beats S2 (A0)
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00, 1, 2'd1, 2'd1, 0);
        step("youngest_s1");
        // load-use: one stall cycle
        drive(1, 1, 2'd2, 8'hEE, 1, 8'h00, 1, 2'd2, 2'd3, 0);
        step("ld_use_stall");
        drive(0, 0, 2'd0, 8'h00, 0, 8'h7E, 1, 2'd2, 2'd3, 0);
        step("ld_use_s1");
        // load value now captured in S2
        drive(0, 0, 2'd0, 8'h00, 0, 8'h99, 1, 2'd2, 2'd0, 0);
        step("ld_s2");
        // load-use killed by flush
        drive(1, 1, 2'd1, 8'hEE, 1, 8'h00, 1, 2'd1, 2'd1, 1);
        step("ld_flush");
        // ex_wen low must not forward
        drive(1, 0, 2'd3, 8'hC3, 0, 8'h00, 1, 2'd3, 2'd3, 0);
        step("no_wen");

        for (int n = 0; n < 60; n++) begin
            drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            step("rand");
        end

        // reset arriving mid-stall
        drive(1, 1, 2'd2, 8'hEE, 1, 8'h00, 1, 2'd2, 2'd2, 0);
        #1;
        check_val("pre_rst_stall", 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(posedge clk);
        #1;
        check_zero_outputs("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(0, 0, 2'd0, 8'h00, 0, 8'h00, 1, 2'd2, 2'd1, 0);
        step("post_rst");

        // saturation of the forwarded-operand counter
        force dut.fwd_count_q = 16'hFFFE;
        #1;
        release dut.fwd_count_q;
        m_cnt = 16'hFFFE;
        drive(1, 1, 2'd1, 8'h12, 0, 8'h00, 1, 2'd1, 2'd1, 0);
        step("sat_hit");
        drive(1, 1, 2'd1, 8'h34, 0, 8'h00, 1, 2'd1, 2'd1, 0);
        step("sat_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
